// File: rtl/wb_chk_pkg.sv
// Shared definitions for the Wishbone initiator-side protocol checker:
// violation flag bit positions, the cycle FSM state type and a small helper.
package wb_chk_pkg;

    localparam int VIOL_WIDTH      = 7;

    localparam int VIOL_MULTI_TERM = 0;
    localparam int VIOL_SPUR_TERM  = 1;
    localparam int VIOL_OVERFLOW   = 2;
    localparam int VIOL_CYC_DROP   = 3;
    localparam int VIOL_TIMEOUT    = 4;
    localparam int VIOL_UNSTABLE   = 5;
    localparam int VIOL_STB_NO_CYC = 6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CYCLE = 1'b1
    } chk_state_e;

    // True when at least two of the three termination strobes are high.
    function automatic logic multi_hot3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/wb_chk_tmo.sv
// Termination timeout counter: counts consecutive run cycles and flags the
// cycle on which the TIMEOUT-th consecutive run sample is seen.
module wb_chk_tmo #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic sync_rst_i,
    input  logic run_i,
    input  logic restart_i,
    output logic expired_o
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired_o = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;

            // Saturates at LAST so a long stall keeps reporting expiry.
            always_comb begin
                cnt_next = cnt_reg;
                if (restart_i) begin
                    cnt_next = '0;
                end else if (run_i && (cnt_reg != LAST)) begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            always_ff @(posedge clk_i) begin
                if (sync_rst_i) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign expired_o = run_i && !restart_i && (cnt_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/wb_itr_chk.sv
// Passive Wishbone initiator-side checker: tracks outstanding requests and
// raises sticky protocol violation flags. It never drives the bus.
module wb_itr_chk
    import wb_chk_pkg::*;
#(
    parameter int ADR_WIDTH  = 16,
    parameter int DAT_WIDTH  = 16,
    parameter int SEL_WIDTH  = 2,
    parameter int TGA_WIDTH  = 1,
    parameter int TGC_WIDTH  = 1,
    parameter int TGWD_WIDTH = 1,
    parameter int MAX_OUT    = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk_i,
    input  logic                          sync_rst_i,
    input  logic                          itr_cyc_i,
    input  logic                          itr_stb_i,
    input  logic                          itr_we_i,
    input  logic                          itr_lock_i,
    input  logic [SEL_WIDTH-1:0]          itr_sel_i,
    input  logic [ADR_WIDTH-1:0]          itr_adr_i,
    input  logic [DAT_WIDTH-1:0]          itr_dat_i,
    input  logic [TGA_WIDTH-1:0]          itr_tga_i,
    input  logic [TGC_WIDTH-1:0]          itr_tgc_i,
    input  logic [TGWD_WIDTH-1:0]         itr_tgd_i,
    input  logic                          itr_ack_o,
    input  logic                          itr_err_o,
    input  logic                          itr_rty_o,
    input  logic                          itr_stall_o,
    input  logic                          clr_i,
    output logic [VIOL_WIDTH-1:0]         viol_o,
    output logic                          irq_o,
    output logic [$clog2(MAX_OUT+1)-1:0]  outst_o
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
    localparam int FW = 2 + SEL_WIDTH + ADR_WIDTH + DAT_WIDTH
                      + TGA_WIDTH + TGC_WIDTH + TGWD_WIDTH;

    logic                  req;
    logic                  term;
    logic                  stalled;
    logic [FW-1:0]         fields;

    chk_state_e            state_reg;
    chk_state_e            state_next;
    logic [CW-1:0]         cnt_reg;
    logic [CW-1:0]         cnt_next;
    logic                  cap_valid_reg;
    logic [FW-1:0]         cap_reg;
    logic [VIOL_WIDTH-1:0] new_viol;
    logic [VIOL_WIDTH-1:0] viol_reg;
    logic [VIOL_WIDTH-1:0] viol_next;

    logic                  tmo_run;
    logic                  tmo_restart;
    logic                  tmo_expired;

    assign req     = itr_cyc_i & itr_stb_i & ~itr_stall_o;
    assign term    = itr_ack_o | itr_err_o | itr_rty_o;
    assign stalled = itr_cyc_i & itr_stb_i & itr_stall_o;

    // Every request qualifier that must hold still while the target stalls.
    assign fields = {itr_we_i, itr_lock_i, itr_sel_i, itr_adr_i,
                     itr_dat_i, itr_tga_i, itr_tgc_i, itr_tgd_i};

    // The timer only runs while something is outstanding and unanswered.
    assign tmo_run     = (cnt_reg != '0) && !term;
    assign tmo_restart = term || (cnt_reg == '0);

    wb_chk_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk_i      (clk_i),
        .sync_rst_i (sync_rst_i),
        .run_i      (tmo_run),
        .restart_i  (tmo_restart),
        .expired_o  (tmo_expired)
    );

    always_comb begin
        state_next = itr_cyc_i ? ST_CYCLE : ST_IDLE;
    end

    // A request and a termination in the same cycle cancel out.
    always_comb begin
        cnt_next = cnt_reg;
        if (!itr_cyc_i) begin
            cnt_next = '0;
        end else if (req && !term) begin
            if (cnt_reg != MAX_CNT) begin
                cnt_next = cnt_reg + CW'(1);
            end
        end else if (term && !req) begin
            if (cnt_reg != '0) begin
                cnt_next = cnt_reg - CW'(1);
            end
        end
    end

    always_comb begin
        new_viol                  = '0;
        new_viol[VIOL_MULTI_TERM] = multi_hot3(itr_ack_o, itr_err_o, itr_rty_o);
        new_viol[VIOL_SPUR_TERM]  = term && (cnt_reg == '0);
        new_viol[VIOL_OVERFLOW]   = req && (cnt_reg == MAX_CNT) && !term;
        new_viol[VIOL_CYC_DROP]   = (state_reg == ST_CYCLE) && !itr_cyc_i && (cnt_reg != '0);
        new_viol[VIOL_TIMEOUT]    = tmo_expired;
        new_viol[VIOL_UNSTABLE]   = cap_valid_reg && itr_stb_i && (fields != cap_reg);
        new_viol[VIOL_STB_NO_CYC] = itr_stb_i && !itr_cyc_i;
    end

    // A fresh violation outranks a clear arriving in the same cycle.
    generate
        for (genvar gi = 0; gi < VIOL_WIDTH; gi++) begin : g_flag
            assign viol_next[gi] = new_viol[gi] | (viol_reg[gi] & ~clr_i);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            cap_valid_reg <= 1'b0;
            cap_reg       <= '0;
            viol_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            cap_valid_reg <= stalled;
            cap_reg       <= fields;
            viol_reg      <= viol_next;
        end
    end

    assign viol_o  = viol_reg;
    assign irq_o   = |viol_reg;
    assign outst_o = cnt_reg;

endmodule

// File: tb/tb_wb_itr_chk.sv
// Directed bench for wb_itr_chk with a cycle-level reference model and
// literal expectations for each protocol scenario.
module tb_wb_itr_chk;

    localparam int MAXO = 4;
    localparam int TMO  = 16;
    localparam int FW   = 39;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we, lock, stall, ack, err, rty, clr;
    logic [1:0]  sel;
    logic [15:0] adr, dat;
    logic        tga, tgc, tgd;
    logic [6:0]  viol;
    logic        irq;
    logic [2:0]  outst;

    always #5 clk = ~clk;

    wb_itr_chk #(
        .ADR_WIDTH (16), .DAT_WIDTH (16), .SEL_WIDTH (2),
        .TGA_WIDTH (1),  .TGC_WIDTH (1),  .TGWD_WIDTH (1),
        .MAX_OUT   (MAXO), .TIMEOUT (TMO)
    ) dut (
        .clk_i       (clk),
        .sync_rst_i  (rst),
        .itr_cyc_i   (cyc),
        .itr_stb_i   (stb),
        .itr_we_i    (we),
        .itr_lock_i  (lock),
        .itr_sel_i   (sel),
        .itr_adr_i   (adr),
        .itr_dat_i   (dat),
        .itr_tga_i   (tga),
        .itr_tgc_i   (tgc),
        .itr_tgd_i   (tgd),
        .itr_ack_o   (ack),
        .itr_err_o   (err),
        .itr_rty_o   (rty),
        .itr_stall_o (stall),
        .clr_i       (clr),
        .viol_o      (viol),
        .irq_o       (irq),
        .outst_o     (outst)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: plain counters and a snapshot of the stalled request.
    int          m_cnt   = 0;
    int          m_quiet = 0;
    logic [6:0]  m_viol  = '0;
    bit          m_capv  = 1'b0;
    logic [FW-1:0] m_cap = '0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        int          nterm;
        bit          term_s, req_s;
        logic [6:0]  nv;
        logic [FW-1:0] cur;
        cur = {we, lock, sel, adr, dat, tga, tgc, tgd};
        if (rst) begin
            started = 1'b1;
            m_cnt = 0; m_quiet = 0; m_viol = '0; m_capv = 1'b0;
        end else begin
            nterm  = int'(ack) + int'(err) + int'(rty);
            term_s = (nterm > 0);
            req_s  = cyc && stb && !stall;
            nv     = '0;
            nv[0]  = (nterm >= 2);
            nv[1]  = term_s && (m_cnt == 0);
            nv[2]  = req_s && (m_cnt == MAXO) && !term_s;
            nv[3]  = !cyc && (m_cnt != 0);
            if (m_cnt != 0 && !term_s) m_quiet++;
            else                       m_quiet = 0;
            nv[4]  = (m_quiet >= TMO);
            nv[5]  = m_capv && stb && (cur != m_cap);
            nv[6]  = stb && !cyc;
            m_viol = clr ? nv : (m_viol | nv);
            if (!cyc)                  m_cnt = 0;
            else if (req_s && !term_s) m_cnt = (m_cnt < MAXO) ? m_cnt + 1 : m_cnt;
            else if (term_s && !req_s) m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
            m_capv = cyc && stb && stall;
            m_cap  = cur;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("outst_model", 32'(outst), 32'(m_cnt));
            check("viol_model",  32'(viol),  32'(m_viol));
            check("irq_model",   32'(irq),   32'(|m_viol));
            $display("cycle t=%0t rst=%b cyc=%b stb=%b stall=%b adr=%h a/e/r=%b%b%b clr=%b outst=%0d viol=%b irq=%b",
                     $time, rst, cyc, stb, stall, adr, ack, err, rty, clr, outst, viol, irq);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; lock = 1'b0; stall = 1'b0;
        ack = 1'b0; err = 1'b0; rty = 1'b0; clr = 1'b0;
        sel = 2'b11; adr = 16'h0100; dat = 16'hA5A5; tga = 1'b0; tgc = 1'b0; tgd = 1'b0;
        tick(); tick();
        check("reset_outst", 32'(outst), 32'd0);
        check("reset_viol",  32'(viol),  32'd0);
        check("reset_irq",   32'(irq),   32'd0);
        rst = 1'b0;

        // Three requests, a wait cycle, three acks, then release the bus.
        cyc = 1'b1; stb = 1'b1;
        tick(); check("seq_outst1", 32'(outst), 32'd1);
        adr = 16'h0104; tick(); check("seq_outst2", 32'(outst), 32'd2);
        adr = 16'h0108; tick(); check("seq_outst3", 32'(outst), 32'd3);
        stb = 1'b0; tick(); check("seq_hold3", 32'(outst), 32'd3);
        ack = 1'b1;
        tick(); check("seq_outst2b", 32'(outst), 32'd2);
        tick(); check("seq_outst1b", 32'(outst), 32'd1);
        tick(); check("seq_outst0",  32'(outst), 32'd0);
        ack = 1'b0; cyc = 1'b0;
        tick(); check("seq_noviol", 32'(viol), 32'd0);

        // ack and err together, then clear.
        cyc = 1'b1; stb = 1'b1;
        tick(); check("multi_outst", 32'(outst), 32'd1);
        stb = 1'b0; ack = 1'b1; err = 1'b1;
        tick();
        check("multi_viol", 32'(viol), 32'b0000001);
        check("multi_irq",  32'(irq),  32'd1);
        ack = 1'b0; err = 1'b0; cyc = 1'b0; clr = 1'b1;
        tick(); clr = 1'b0;
        check("multi_clr_viol", 32'(viol), 32'd0);
        check("multi_clr_irq",  32'(irq),  32'd0);

        // Five back-to-back requests against a limit of four.
        cyc = 1'b1; stb = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("ovf_fill_outst", 32'(outst), 32'(i));
            check("ovf_fill_viol",  32'(viol),  32'd0);
        end
        tick();
        check("ovf_viol",  32'(viol),  32'b0000100);
        check("ovf_outst", 32'(outst), 32'd4);
        stb = 1'b0; ack = 1'b1;
        repeat (4) tick();
        check("ovf_drain", 32'(outst), 32'd0);
        ack = 1'b0; cyc = 1'b0; clr = 1'b1;
        tick(); clr = 1'b0;
        check("ovf_clr", 32'(viol), 32'd0);

        // One outstanding request left unanswered for sixteen cycles.
        cyc = 1'b1; stb = 1'b1;
        tick(); stb = 1'b0;
        repeat (15) tick();
        check("tmo_pre_viol",  32'(viol),  32'd0);
        check("tmo_pre_outst", 32'(outst), 32'd1);
        tick();
        check("tmo_viol", 32'(viol), 32'b0010000);
        ack = 1'b1; tick(); check("tmo_ack_outst", 32'(outst), 32'd0);
        ack = 1'b0; cyc = 1'b0; clr = 1'b1;
        tick(); clr = 1'b0;
        check("tmo_clr", 32'(viol), 32'd0);

        // Same again, answered on the fifteenth cycle.
        cyc = 1'b1; stb = 1'b1;
        tick(); stb = 1'b0;
        repeat (14) tick();
        ack = 1'b1; tick(); ack = 1'b0;
        repeat (4) tick();
        check("tmo_ok_viol", 32'(viol), 32'd0);
        cyc = 1'b0; tick();
        check("tmo_ok_viol2", 32'(viol), 32'd0);

        // Address changes while stalled.
        cyc = 1'b1; stb = 1'b1; stall = 1'b1; adr = 16'h1000;
        tick();
        adr = 16'h1002; tick();
        check("unst_viol", 32'(viol), 32'b0100000);
        stall = 1'b0; tick(); check("unst_outst", 32'(outst), 32'd1);
        stb = 1'b0; ack = 1'b1; tick();
        ack = 1'b0; cyc = 1'b0; clr = 1'b1;
        tick(); clr = 1'b0;
        check("unst_clr", 32'(viol), 32'd0);

        // Address changes only once the stall has been released.
        cyc = 1'b1; stb = 1'b1; stall = 1'b1; adr = 16'h1000;
        tick(); tick();
        stall = 1'b0; tick(); check("stab_outst", 32'(outst), 32'd1);
        adr = 16'h1002; tick();
        check("stab_viol",   32'(viol),  32'd0);
        check("stab_outst2", 32'(outst), 32'd2);
        stb = 1'b0; ack = 1'b1; tick(); tick();
        ack = 1'b0; cyc = 1'b0; tick();
        check("stab_viol2", 32'(viol), 32'd0);

        // Strobe without cycle, then a clear colliding with a spurious ack.
        stb = 1'b1; tick();
        check("snc_viol", 32'(viol), 32'b1000000);
        stb = 1'b0; ack = 1'b1; clr = 1'b1; tick();
        check("clr_vs_new", 32'(viol), 32'b0000010);
        ack = 1'b0; tick(); clr = 1'b0;
        check("clr_final", 32'(viol), 32'd0);

        // Reset in the middle of a transaction.
        cyc = 1'b1; stb = 1'b1; adr = 16'h2000;
        tick(); tick();
        check("rst_pre_outst", 32'(outst), 32'd2);
        stb = 1'b0; rst = 1'b1; tick();
        check("rst_outst", 32'(outst), 32'd0);
        check("rst_viol",  32'(viol),  32'd0);
        rst = 1'b0; cyc = 1'b0; tick();
        check("rst_nodrop", 32'(viol),  32'd0);
        check("rst_outst2", 32'(outst), 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
